keypad_unit: RTL

//  4x4 matrix-keypad front end that answers the hazard unit's interrupt requests.
//  - Scans and debounces the keypad.
//  - Raises the user requests pause, resume and UART rewrite.
//  - Collects signed decimal entry while the hazard unit holds the CPU in a KEYPAD interrupt.
//  - Delivers the value to data_mem with a completion handshake, and the raw BCD entry to vga_unit.

---
 rtl/keypad_unit_pkg.sv | 25 ++
 rtl/keypad_unit_scanner.sv | 77 +++++++
 rtl/keypad_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/keypad_unit_pkg.sv
// keypad_unit_pkg: issue codes, key codes, FSM encodings and key decode helpers shared by the keypad front end
package keypad_unit_pkg;
  localparam int ISA_WIDTH = 32;
  localparam logic [2:0] ISSUE_NONE   = 3'd0;
  localparam logic [2:0] ISSUE_DATA   = 3'd1;
  localparam logic [2:0] ISSUE_UART   = 3'd2;
  localparam logic [2:0] ISSUE_PAUSE  = 3'd3;
  localparam logic [2:0] ISSUE_KEYPAD = 3'd4;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  // nibble {row,col} holds the code of that key; rows "123A" "456B" "789C" "*0#D"
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SC_SCAN, SC_DEBOUNCE, SC_HELD, SC_RELEASE} scan_state_t;
  typedef enum logic [1:0] {EN_IDLE, EN_ENTRY, EN_CONVERT, EN_DONE} entry_state_t;
  function automatic logic [1:0] low_index(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_unit_scanner.sv
// keypad_scanner: row drive, column synchroniser, press/release debounce, one key_valid pulse per press
module keypad_scanner
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_SETTLE = DW'(SCAN_DIV > 2 ? 2 : 0);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
  logic [3:0] col_s1, col_s2;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  scan_state_t state;
  logic any_low;
  logic [3:0] cur;
  assign any_low = ~&col_s2;
  assign cur = key_lookup(low_index(row_out), low_index(col_s2));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
      row_out <= 4'b1110;
      div <= '0;
      cnt <= '0;
      state <= SC_SCAN;
      key_valid <= 1'b0;
      key_code <= 4'h0;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
      key_valid <= 1'b0;
      case (state)
        // synchronised columns lag the row by two cycles, so only trust them once the row has settled
        SC_SCAN: begin
          if (any_low && div >= DIV_SETTLE) begin
            state <= SC_DEBOUNCE;
            key_code <= cur;
            cnt <= CW'(1);
          end else if (div == DIV_LAST) begin
            div <= '0;
            row_out <= {row_out[2:0], row_out[3]};
          end else div <= div + 1'b1;
        end
        SC_DEBOUNCE: begin
          if (!any_low || cur != key_code) state <= SC_SCAN;
          else if (cnt >= CNT_LAST) begin
            key_valid <= 1'b1;
            state <= SC_HELD;
          end else cnt <= cnt + 1'b1;
        end
        SC_HELD: begin
          if (!any_low) begin
            state <= SC_RELEASE;
            cnt <= CW'(1);
          end
        end
        default: begin
          if (any_low) state <= SC_HELD;
          else if (cnt >= CNT_LAST) begin
            state <= SC_SCAN;
            div <= '0;
          end else cnt <= cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/keypad_unit.sv
// keypad_unit: keypad front end raising pause/resume/UART requests and converting signed BCD entry for data_mem
module keypad_unit
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int MAX_DIGITS   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [3:0]              row_out,
  input  logic [3:0]              col_in,
  input  logic [2:0]              issue_type,
  input  logic                    keypad_read_enable,
  output logic                    keypad_read_complete,
  output logic [ISA_WIDTH-1:0]    keypad_data,
  output logic                    cpu_pause,
  output logic                    cpu_resume,
  output logic                    uart_start,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic                    entry_negative,
  output logic [3:0]              entry_digits
);
  localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);
  logic key_valid;
  logic [3:0] key_code;
  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) u_scanner (
    .clk(clk),
    .rst_n(rst_n),
    .row_out(row_out),
    .col_in(col_in),
    .key_valid(key_valid),
    .key_code(key_code)
  );
  logic paused, grant_pause, leave_pause, grant_uart, paused_n, idle_req, key_a, key_b;
  // grants are folded in before the key so a same-cycle key sees the post-grant state
  assign grant_pause = cpu_pause && issue_type == ISSUE_PAUSE;
  assign leave_pause = cpu_resume && issue_type != ISSUE_PAUSE;
  assign grant_uart  = uart_start && issue_type == ISSUE_UART;
  assign paused_n    = (paused || grant_pause) && !leave_pause;
  assign idle_req    = !((cpu_pause && !grant_pause) || (cpu_resume && !leave_pause) || (uart_start && !grant_uart));
  assign key_a       = key_valid && key_code == KEY_A && idle_req;
  assign key_b       = key_valid && key_code == KEY_B && idle_req;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paused <= 1'b0;
      cpu_pause <= 1'b0;
      cpu_resume <= 1'b0;
      uart_start <= 1'b0;
    end else begin
      paused <= paused_n;
      cpu_pause <= (cpu_pause && !grant_pause) || (key_a && !paused_n);
      cpu_resume <= (cpu_resume && !leave_pause) || (key_a && paused_n && issue_type == ISSUE_PAUSE);
      uart_start <= (uart_start && !grant_uart) || (key_b && !paused_n);
    end
  end
  entry_state_t estate;
  logic [3:0] conv_idx, next_digit;
  logic [ISA_WIDTH-1:0] acc, acc_next, conv_val;
  assign next_digit = 4'(entry_bcd >> {conv_idx - 4'd1, 2'b00});
  assign acc_next   = acc * ISA_WIDTH'(10) + ISA_WIDTH'(next_digit);
  assign conv_val   = conv_idx == 4'd0 ? '0 : acc_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estate <= EN_IDLE;
      entry_bcd <= '0;
      entry_digits <= 4'd0;
      entry_negative <= 1'b0;
      conv_idx <= 4'd0;
      acc <= '0;
      keypad_data <= '0;
      keypad_read_complete <= 1'b0;
    end else begin
      case (estate)
        EN_IDLE: if (issue_type == ISSUE_KEYPAD && keypad_read_enable) estate <= EN_ENTRY;
        EN_ENTRY: begin
          if (issue_type != ISSUE_KEYPAD) begin
            entry_bcd <= '0;
            entry_digits <= 4'd0;
            entry_negative <= 1'b0;
            estate <= EN_IDLE;
          end else if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (entry_digits < MAX_D) begin
                entry_bcd <= {entry_bcd[4*MAX_DIGITS-5:0], key_code};
                entry_digits <= entry_digits + 4'd1;
              end
            end else if (key_code == KEY_STAR) begin
              if (entry_digits != 4'd0) begin
                entry_bcd <= entry_bcd >> 4;
                entry_digits <= entry_digits - 4'd1;
              end
            end else if (key_code == KEY_C) begin
              entry_bcd <= '0;
              entry_digits <= 4'd0;
              entry_negative <= 1'b0;
            end else if (key_code == KEY_D) entry_negative <= !entry_negative;
            else if (key_code == KEY_HASH) begin
              acc <= '0;
              conv_idx <= entry_digits;
              estate <= EN_CONVERT;
            end
          end
        end
        // most significant digit sits at nibble conv_idx-1; the last step loads the signed result
        EN_CONVERT: begin
          if (conv_idx <= 4'd1) begin
            keypad_data <= entry_negative ? -conv_val : conv_val;
            keypad_read_complete <= 1'b1;
            estate <= EN_DONE;
          end else begin
            acc <= acc_next;
            conv_idx <= conv_idx - 4'd1;
          end
        end
        default: begin
          if (issue_type != ISSUE_KEYPAD) begin
            keypad_read_complete <= 1'b0;
            entry_bcd <= '0;
            entry_digits <= 4'd0;
            entry_negative <= 1'b0;
            estate <= EN_IDLE;
          end
        end
      endcase
    end
  end
endmodule
